// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared constants and buffer type for the 7-segment scan block
// Revision    : 1.0
// ============================================================================
`default_nettype none

package display_pkg;

    // Upper bound on the digit count; buffers are sized for it and the
    // unused upper digits stay at zero.
    localparam int MAX_DIGITS = 16;

    localparam logic [6:0]            SEG_OFF = 7'b1111111;
    localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] value;
        logic [MAX_DIGITS-1:0]   dp;
        logic [MAX_DIGITS-1:0]   blank;
    } disp_buf_t;

endpackage

`default_nettype wire

// File: rtl/sietesegmentos.sv
// ============================================================================
// sietesegmentos : hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sietesegmentos (
    input  logic [3:0] nibble_i,
    output logic [6:0] sseg_o
);

    always_comb begin
        sseg_o = 7'b1111111;
        case (nibble_i)
            4'h0: sseg_o = 7'b1000000;
            4'h1: sseg_o = 7'b1111001;
            4'h2: sseg_o = 7'b0100100;
            4'h3: sseg_o = 7'b0110000;
            4'h4: sseg_o = 7'b0011001;
            4'h5: sseg_o = 7'b0010010;
            4'h6: sseg_o = 7'b0000010;
            4'h7: sseg_o = 7'b1111000;
            4'h8: sseg_o = 7'b0000000;
            4'h9: sseg_o = 7'b0010000;
            4'hA: sseg_o = 7'b0001000;
            4'hB: sseg_o = 7'b0000011;
            4'hC: sseg_o = 7'b1000110;
            4'hD: sseg_o = 7'b0100001;
            4'hE: sseg_o = 7'b0000110;
            4'hF: sseg_o = 7'b0001110;
            default: sseg_o = 7'b1111111;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// display_scan_ctrl : time-multiplexed common-anode scan with tear-free commit
// Revision          : 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blank,
    input  logic                  i_load,
    output logic [N_DIGITS-1:0]   o_an,
    output logic [6:0]            o_sseg,
    output logic                  o_dp,
    output logic                  o_pending,
    output logic                  o_frame
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = $clog2(MAX_DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    disp_buf_t           disp_q, disp_d;
    disp_buf_t           pend_q, pend_d;
    logic                pending_q, pending_d;
    logic                frame_q;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          sseg_q;
    logic                dp_q;

    logic                tick;
    logic                boundary;
    disp_buf_t           in_buf;
    logic [SW-1:0]       sel;
    logic [3:0]          nibble;
    logic [6:0]          seg_dec;
    logic [N_DIGITS-1:0] onehot;

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    always_comb begin
        in_buf                         = '0;
        in_buf.value[4*N_DIGITS-1:0]   = i_value;
        in_buf.dp[N_DIGITS-1:0]        = i_dp;
        in_buf.blank[N_DIGITS-1:0]     = i_blank;
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // A load on the boundary goes straight to the display image; otherwise it
    // lands in the pending buffer and waits for the next frame edge.
    always_comb begin
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (boundary && i_load) begin
            disp_d    = in_buf;
            pending_d = 1'b0;
        end else begin
            if (boundary && pending_q) begin
                disp_d    = pend_q;
                pending_d = 1'b0;
            end
            if (i_load) begin
                pend_d    = in_buf;
                pending_d = 1'b1;
            end
        end
    end

    assign sel    = SW'(idx_q);
    assign nibble = disp_q.value[{sel, 2'b00} +: 4];

    sietesegmentos u_dec (
        .nibble_i (nibble),
        .sseg_o   (seg_dec)
    );

    // presc_q == 0 marks the first cycle of a slot (also right after reset),
    // which is exactly when the anti-ghost blank applies.
    always_comb begin
        onehot        = '0;
        onehot[idx_q] = 1'b1;
        an_d          = ~onehot;
        if ((presc_q == '0) || disp_q.blank[sel]) begin
            an_d = AN_OFF[N_DIGITS-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc_q   <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            an_q      <= AN_OFF[N_DIGITS-1:0];
            sseg_q    <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            frame_q   <= boundary;
            an_q      <= an_d;
            sseg_q    <= seg_dec;
            dp_q      <= ~disp_q.dp[sel];
        end
    end

    assign o_an      = an_q;
    assign o_sseg    = sseg_q;
    assign o_dp      = dp_q;
    assign o_pending = pending_q;
    assign o_frame   = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// tb_display_scan_ctrl : scoreboard bench with a slot-arithmetic reference model
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int FR = N * P;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   val;
    logic [3:0]    dpi;
    logic [3:0]    blk;
    logic          load;
    logic [3:0]    o_an;
    logic [6:0]    o_sseg;
    logic          o_dp;
    logic          o_pending;
    logic          o_frame;

    always #5 clk = ~clk;

    display_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_value   (val),
        .i_dp      (dpi),
        .i_blank   (blk),
        .i_load    (load),
        .o_an      (o_an),
        .o_sseg    (o_sseg),
        .o_dp      (o_dp),
        .o_pending (o_pending),
        .o_frame   (o_frame)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
        logic       pend;
        logic       frame;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: c counts clock edges since reset release.
    int          c = 0;
    logic [15:0] m_dval = '0, m_pval = '0;
    logic [3:0]  m_ddp = '0, m_pdp = '0, m_dbl = '0, m_pbl = '0;
    bit          m_pending = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit ld, input logic [15:0] v,
                        input logic [3:0] d, input logic [3:0] b);
        exp_t       e;
        int         ps, ix;
        bit         bnd;
        logic [3:0] oh;
        @(negedge clk);
        rst = r; load = ld; val = v; dpi = d; blk = b;
        if (r) begin
            e.an = 4'hF; e.sseg = 7'h7F; e.dp = 1'b1; e.pend = 1'b0; e.frame = 1'b0;
            c = 0;
            m_dval = '0; m_pval = '0; m_ddp = '0; m_pdp = '0; m_dbl = '0; m_pbl = '0;
            m_pending = 1'b0;
        end else begin
            ps  = c % P;
            ix  = (c / P) % N;
            bnd = (ps == P - 1) && (ix == N - 1);
            oh  = 4'b0001 << ix;
            e.an    = (ps == 0 || m_dbl[ix]) ? 4'hF : ~oh;
            e.sseg  = SEG_TAB[m_dval[ix*4 +: 4]];
            e.dp    = ~m_ddp[ix];
            e.frame = bnd;
            if (bnd && ld) begin
                m_dval = v; m_ddp = d; m_dbl = b; m_pending = 1'b0;
            end else begin
                if (bnd && m_pending) begin
                    m_dval = m_pval; m_ddp = m_pdp; m_dbl = m_pbl; m_pending = 1'b0;
                end
                if (ld) begin
                    m_pval = v; m_pdp = d; m_pbl = b; m_pending = 1'b1;
                end
            end
            e.pend = m_pending;
            c++;
        end
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_until(input int phase);
        int guard;
        guard = 0;
        while ((c % FR) != phase && guard < 2 * FR) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
            guard++;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("an",      {4'h0, o_an},      {4'h0, e.an});
            chk("sseg",    {1'b0, o_sseg},    {1'b0, e.sseg});
            chk("dp",      {7'h0, o_dp},      {7'h0, e.dp});
            chk("pending", {7'h0, o_pending}, {7'h0, e.pend});
            chk("frame",   {7'h0, o_frame},   {7'h0, e.frame});
        end
    end

    initial begin
        bit          r, ld;
        logic [15:0] rv;
        rst = 1'b1; load = 1'b0; val = '0; dpi = '0; blk = '0;

        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(20);

        step(1'b0, 1'b1, 16'h4321, 4'h0, 4'h0);
        idle(40);

        idle_until(6);
        step(1'b0, 1'b1, 16'hABCD, 4'h0, 4'h0);
        idle(40);

        idle_until(FR - 1);
        step(1'b0, 1'b1, 16'h5A6B, 4'h0, 4'h0);
        idle(40);

        step(1'b0, 1'b1, 16'h8765, 4'b0001, 4'b0100);
        idle(40);

        idle_until(5);
        step(1'b0, 1'b1, 16'h9999, 4'hF, 4'h0);
        idle(3);
        repeat (2) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(40);

        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ((c % FR) == FR - 1) ? $urandom_range(0, 1) == 1
                                      : $urandom_range(0, 7) == 0;
            rv = 16'($urandom);
            step(r, ld, rv, 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end
        idle(10);

        @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller that shares one `sietesegmentos` decoder across `N_DIGITS` common-anode digits. It holds a double-buffered display image, steps a digit index at a prescaled rate, and drives the anode enables, segment lines and decimal point. New values are committed only at frame boundaries, so a digit never shows a mix of old and new data. The block sits between the application logic that produces BCD/hex nibbles and the board's 7-segment pins.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits; at least 2.
- `PRESCALE`, 50000: clock cycles per digit slot; at least 2.
- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_value`  in  4*N_DIGITS  nibble per digit; digit k is bits [4k+3:4k], and digit 0 is the rightmost.
- `i_dp`  in  N_DIGITS  decimal-point request per digit; 1 = lit.
- `i_blank`  in  N_DIGITS  per-digit blanking; 1 = digit dark.
- `i_load`  in  1  one-cycle strobe; captures `i_value`, `i_dp` and `i_blank` into the pending buffer.
- `o_an`  out  N_DIGITS  anode enables, active-low; at most one bit is 0.
- `o_sseg`  out  7  segments {g,f,e,d,c,b,a}, active-low, taken from `sietesegmentos`.
- `o_dp`  out  1  decimal point, active-low.
- `o_pending`  out  1  pending buffer holds data that has not yet been committed.
- `o_frame`  out  1  one-cycle pulse at each frame boundary.

## Operation
**Prescaler**
- `presc` counts 0..PRESCALE-1 and wraps.
- `tick` = (`presc` == PRESCALE-1).

**Digit index**
- `idx` advances on `tick`, counting 0..N_DIGITS-1 and wrapping to 0.
- The boundary is the cycle where `tick` is high and `idx` == N_DIGITS-1.

**Buffers**
- The pending buffer and the display buffer each hold {value, dp, blank}.
- On `i_load`, the pending buffer captures the inputs and `o_pending` is set to 1.
- On a boundary with `o_pending` = 1, the display buffer takes the pending buffer and `o_pending` clears.
- `i_load` on the boundary cycle: the inputs go directly to the display buffer (bypass) and `o_pending` stays 0.
- Repeated `i_load` before a boundary: the last load wins, and earlier loads are discarded without any indication.

**Output stage (registered)**
- `o_sseg` = decode(display.value[`idx`]).
- `o_dp` = ~display.dp[`idx`].
- `o_an` = all ones except bit `idx`, which is 0. If display.blank[`idx`] = 1, `o_an` is all ones.
- Anti-ghosting: in the first cycle after `idx` changes, `o_an` is forced to all ones.

**Reset (asynchronous, while `i_reset` is high)**
- `presc` = 0, `idx` = 0.
- Both buffers = 0, so value 0, no decimal points, no blanking.
- `o_pending` = 0, `o_frame` = 0.
- `o_an` = all ones, `o_sseg` = 7'b1111111, `o_dp` = 1.
- Asserting reset mid-frame discards pending data.

## Timing
- One slot is PRESCALE cycles and one frame is N_DIGITS*PRESCALE cycles.
- The `idx` update happens 1 cycle after `tick`.
- The output registers reflect a new `idx` or new display data 1 cycle after it changes.
- Each slot drives its anode low for PRESCALE-1 cycles, because of the 1-cycle anti-ghost blank.
- `o_frame` is high in the cycle after the boundary, coincident with `idx` = 0 becoming visible in state.
- Load-to-visible worst case: N_DIGITS*PRESCALE + 2 cycles.
- First anode activity after reset release: cycle 2, because the first cycle is the anti-ghost blank.

## Structure
- The shared package `display_pkg` holds:
  - the segment constants `SEG_OFF` = 7'b1111111 and `AN_OFF`;
  - the typedef `disp_buf_t` {value, dp, blank}.
- `idx` width is $clog2(N_DIGITS); `presc` width is $clog2(PRESCALE).
- The single sub-module is the existing `sietesegmentos` (4-bit in, 7-bit active-low out). Instantiate it combinationally on the mux output and register its output here.
- No other hierarchy.

## Test plan
All scenarios use N_DIGITS = 4 and PRESCALE = 4.
- **Reset:** hold `i_reset`, then release → `o_an` = 4'b1111, `o_sseg` = 7'b1111111, `o_dp` = 1, `o_pending` = 0. The first active anode is 4'b1110, driving digit 0 with the decode of 0.
- **Scan:** load `i_value` = 16'h4321, no blanking → `o_an` cycles 1110→1101→1011→0111. Each code is held 3 cycles with a 1-cycle 1111 gap in between. `o_sseg` shows the decode of 1, 2, 3, 4 in turn, and `o_frame` pulses every 16 cycles.
- **Tear-free commit:** pulse `i_load` with 16'hABCD mid-frame → `o_pending` = 1. Digits keep showing the old value until the next `o_frame`, after which digit 0 shows D and `o_pending` = 0.
- **Boundary bypass:** pulse `i_load` in the boundary cycle (`idx` = 3, `presc` = 3) → the new value is shown on digit 0 of the next frame, and `o_pending` never rises.
- **Blank and decimal point:** `i_blank` = 4'b0100, `i_dp` = 4'b0001 → slot 2 holds `o_an` = 1111 for all 4 cycles. `o_dp` = 0 only while digit 0 is active.
- **Reset mid-frame:** assert reset while `o_pending` = 1 → all outputs immediately return to their reset values and the pending data is lost.
